pr_elastic_stage: RTL and testbench
===================================

# pr_elastic_stage

Parametrised, elastic successor to the fixed IF/ID pipeline register. It carries a WIDTH-bit payload between two CPU pipeline stages using a valid/ready handshake and a 2-entry skid buffer, so back-pressure never needs a combinational ready path. It also keeps the existing HOLD (freeze) and adds FLUSH (bubble insertion) and a saturating stall counter. All inter-stage registers of the next core revision (IF/ID, ID/EX, EX/MEM, MEM/WB) are instances of this block.

## Interface
Parameters:
- WIDTH, 64, payload width in bits (e.g. PC concatenated with INSTRUCTION); must be ≥ 1.
- CNT_WIDTH, 16, stall counter width; must be ≥ 1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- FLUSH  in  1  synchronous; discards all held entries.
- HOLD  in  1  freezes all state; no transfers on either side.
- IN_VALID  in  1  upstream has data.
- IN_DATA  in  WIDTH  upstream payload.
- IN_READY  out  1  stage can accept data; driven from a register only.
- OUT_VALID  out  1  OUT_DATA is valid.
- OUT_DATA  out  WIDTH  payload presented downstream.
- OUT_READY  in  1  downstream accepts.
- STALL_COUNT  out  CNT_WIDTH  saturating count of cycles with OUT_VALID=1 and OUT_READY=0.

## Operation
- Storage: main register (main_v, main_d) drives the OUT_* ports. Skid register (skid_v, skid_d) holds one extra entry.
- Transfer rules:
  - Input transfer: IN_VALID & IN_READY & ~HOLD.
  - Output transfer: OUT_VALID & OUT_READY & ~HOLD.
- States, encoded by {main_v, skid_v}:
  - EMPTY (00):
    - input transfer → ONE.
  - ONE (10):
    - input and output transfers together → ONE; main_d takes IN_DATA.
    - input transfer only → FULL; skid_d takes IN_DATA.
    - output transfer only → EMPTY.
  - FULL (11):
    - IN_READY=0.
    - output transfer → ONE; main_d takes skid_d, and skid_v clears.
- IN_READY = ~skid_v & ~HOLD. HOLD is the only combinational term.
- Priority, highest first: RESET > FLUSH > HOLD > normal handshake.
  - FLUSH: main_v and skid_v clear and both data registers are set to 0. Any input offered in that cycle is dropped. STALL_COUNT is unaffected.
  - HOLD: no register changes, including STALL_COUNT. OUT_VALID and OUT_DATA stay stable.
- Payload is never reordered, duplicated or lost, except by FLUSH or RESET.
- STALL_COUNT increments when OUT_VALID & ~OUT_READY & ~HOLD & ~FLUSH. It saturates at 2^CNT_WIDTH−1 and does not wrap.

## Timing
- Reset values (RESET=1 at an edge): OUT_VALID=0, OUT_DATA=0, skid cleared, IN_READY=1 on the following cycle, STALL_COUNT=0.
- Latency: data accepted at edge N appears on OUT_DATA/OUT_VALID after edge N when the stage was EMPTY, or when ONE with a simultaneous output transfer.
- Throughput: one transfer per cycle in steady state with OUT_READY=1.
- Back-pressure: when OUT_READY drops, the stage absorbs at most one more beat, then IN_READY falls after the next edge. IN_READY rises one edge after OUT_READY returns.
- FLUSH and RESET asserted in the same cycle: RESET wins. The outcome is identical except that STALL_COUNT clears.
- RESET in the middle of back-pressure, in any state: the stage is EMPTY after the edge.
- HOLD together with FLUSH: the flush takes effect.

## Structure
- Shared package pr_pkg holds:
  - the state encoding constants ST_EMPTY, ST_ONE, ST_FULL;
  - the default WIDTH and CNT_WIDTH;
  - a NOP payload constant of 0 used for flush and reset values.
- One sub-module is natural: pr_sat_counter (parameter CNT_WIDTH; inputs CLK, RESET, INC; output COUNT), reused by the performance-counter block.

## Test plan
- Reset: drive RESET for 2 cycles with IN_VALID=1, IN_DATA=0xA5 → OUT_VALID=0, OUT_DATA=0, STALL_COUNT=0, IN_READY=1 after release.
- Streaming: OUT_READY=1, push 0x1,0x2,…,0x10 on consecutive cycles → the same sequence appears on OUT_DATA one cycle later, with no gaps.
- Back-pressure: fill with 0x11, hold OUT_READY=0 and offer 0x22, 0x33:
  - 0x22 is captured in skid, IN_READY falls, and 0x33 is held upstream.
  - Release OUT_READY → output is 0x11, 0x22, 0x33, in order.
  - STALL_COUNT equals the number of stalled cycles.
- Flush: in FULL with 0x44/0x55 held, assert FLUSH for 1 cycle while offering 0x66 → next cycle OUT_VALID=0, OUT_DATA=0, IN_READY=1, and 0x66 never appears.
- Hold: in ONE with 0x77, assert HOLD for 3 cycles with OUT_READY=1, IN_VALID=1 → OUT_DATA stays 0x77, IN_READY=0 and STALL_COUNT stays constant throughout; 0x77 transfers on the first cycle after HOLD drops.
- Saturation: CNT_WIDTH=4, stall for 20 cycles → STALL_COUNT reaches 15 and stays at 15.

Source files
------------

// File: rtl/pr_pkg.sv
// Shared constants for the elastic pipeline-register family.
// State encoding is {main_v, skid_v}.
package pr_pkg;
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam int DEF_WIDTH     = 64;
  localparam int DEF_CNT_WIDTH = 16;

  // Bubble payload loaded on flush and reset; resized to the instance width at use.
  localparam logic [DEF_WIDTH-1:0] NOP_PAYLOAD = '0;
endpackage

// File: rtl/pr_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module pr_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 INC,
  output logic [CNT_WIDTH-1:0] COUNT
);
  always_ff @(posedge CLK) begin
    if (RESET)
      COUNT <= '0;
    else if (INC && (COUNT != '1))
      COUNT <= COUNT + CNT_WIDTH'(1);
  end
endmodule

// File: rtl/pr_elastic_stage.sv
// Elastic inter-stage register: main + skid entry, valid/ready handshake,
// HOLD freeze, FLUSH bubble insertion and a saturating stall counter.
module pr_elastic_stage
  import pr_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FLUSH,
  input  logic                 HOLD,
  input  logic                 IN_VALID,
  input  logic [WIDTH-1:0]     IN_DATA,
  output logic                 IN_READY,
  output logic                 OUT_VALID,
  output logic [WIDTH-1:0]     OUT_DATA,
  input  logic                 OUT_READY,
  output logic [CNT_WIDTH-1:0] STALL_COUNT
);
  localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_PAYLOAD);

  logic             main_v, skid_v;
  logic [WIDTH-1:0] main_d, skid_d;
  logic             in_xfer, out_xfer;

  // Ready comes from the skid flag; HOLD is the only combinational term.
  assign IN_READY  = ~skid_v & ~HOLD;
  assign OUT_VALID = main_v;
  assign OUT_DATA  = main_d;
  assign in_xfer   = IN_VALID & IN_READY;
  assign out_xfer  = main_v & OUT_READY & ~HOLD;

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= NOP;
      skid_d <= NOP;
    end else if (!HOLD) begin
      case ({main_v, skid_v})
        ST_EMPTY: begin
          if (in_xfer) begin
            main_v <= 1'b1;
            main_d <= IN_DATA;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d <= IN_DATA;
          end else if (in_xfer) begin
            skid_v <= 1'b1;
            skid_d <= IN_DATA;
          end else if (out_xfer) begin
            main_v <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
          end
        end
        default: begin
          // Skid without main is unreachable; drop the orphan entry.
          skid_v <= 1'b0;
        end
      endcase
    end
  end

  pr_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (main_v & ~OUT_READY & ~HOLD & ~FLUSH),
    .COUNT (STALL_COUNT)
  );
endmodule

// File: tb/tb_pr_elastic_stage.sv
// Scoreboard bench for pr_elastic_stage: accepted beats are queued, a negedge
// monitor pops and compares on every output transfer; directed checks cover state.
module tb_pr_elastic_stage;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst, flush, hold;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [15:0]   stall;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [W-1:0]  s_in_data, s_out_data;
  logic [3:0]    s_stall;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pr_elastic_stage #(.WIDTH(W), .CNT_WIDTH(16)) dut (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .HOLD(hold),
    .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(in_ready),
    .OUT_VALID(out_valid), .OUT_DATA(out_data), .OUT_READY(out_ready),
    .STALL_COUNT(stall)
  );

  pr_elastic_stage #(.WIDTH(W), .CNT_WIDTH(4)) dut_sat (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .HOLD(hold),
    .IN_VALID(s_in_valid), .IN_DATA(s_in_data), .IN_READY(s_in_ready),
    .OUT_VALID(s_out_valid), .OUT_DATA(s_out_data), .OUT_READY(s_out_ready),
    .STALL_COUNT(s_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  // Monitor: pop on each output transfer, then update the queue with this cycle's input.
  always @(negedge clk) begin
    if (!rst && !flush && !hold && out_valid && out_ready) begin
      if (exp_q.size() == 0)
        chk("unexpected_out", {24'd0, out_data}, 32'hFFFF_FFFF);
      else
        chk("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
    if (rst || flush)
      exp_q.delete();
    else if (!hold && in_valid && in_ready)
      exp_q.push_back(in_data);
  end

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic cyc(input logic r, input logic f, input logic h,
                     input logic iv, input logic [W-1:0] id, input logic ordy);
    @(posedge clk);
    #1;
    rst = r; flush = f; hold = h;
    in_valid = iv; in_data = id; out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;

    // Reset with input offered
    cyc(1, 0, 0, 1, 8'hA5, 0);
    cyc(1, 0, 0, 1, 8'hA5, 0);
    cyc(0, 0, 0, 0, 8'h00, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_stall", {16'd0, stall}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming 0x01..0x10, no gaps
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 0, 1, W'(i), 1);
      if (i >= 2) begin
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_data", {24'd0, out_data}, 32'(i - 1));
      end
    end
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("stream_last", {24'd0, out_data}, 32'h10);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("stream_drained", {31'd0, out_valid}, 32'd0);
    chk("stream_no_stall", {16'd0, stall}, 32'd0);

    // Back-pressure
    cyc(0, 0, 0, 1, 8'h11, 0);
    cyc(0, 0, 0, 1, 8'h22, 0);
    chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
    cyc(0, 0, 0, 1, 8'h33, 0);
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_data_held", {24'd0, out_data}, 32'h11);
    cyc(0, 0, 0, 1, 8'h33, 0);
    chk("bp_ready_full2", {31'd0, in_ready}, 32'd0);
    cyc(0, 0, 0, 1, 8'h33, 1);
    chk("bp_stall_cnt", {16'd0, stall}, 32'd3);
    chk("bp_ready_release", {31'd0, in_ready}, 32'd0);
    cyc(0, 0, 0, 1, 8'h33, 1);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    chk("bp_data_22", {24'd0, out_data}, 32'h22);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("bp_data_33", {24'd0, out_data}, 32'h33);
    chk("bp_stall_final", {16'd0, stall}, 32'd3);

    // Flush while FULL, 0x66 offered
    cyc(0, 0, 0, 1, 8'h44, 0);
    cyc(0, 0, 0, 1, 8'h55, 0);
    cyc(0, 1, 0, 1, 8'h66, 0);
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_data", {24'd0, out_data}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_stall", {16'd0, stall}, 32'd4);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("fl_still_empty", {31'd0, out_valid}, 32'd0);

    // Hold in ONE with 0x77
    cyc(0, 0, 0, 1, 8'h77, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 8'h88, 1);
      chk("hold_data", {24'd0, out_data}, 32'h77);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_stall", {16'd0, stall}, 32'd4);
    end
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("hold_release_data", {24'd0, out_data}, 32'h77);
    chk("hold_release_ready", {31'd0, in_ready}, 32'd1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("hold_sent", {31'd0, out_valid}, 32'd0);

    // Hold together with flush: flush wins
    cyc(0, 0, 0, 1, 8'h99, 0);
    cyc(0, 1, 1, 0, 8'h00, 0);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("hf_valid", {31'd0, out_valid}, 32'd0);
    chk("hf_stall", {16'd0, stall}, 32'd4);

    // Reset + flush while FULL: reset clears stall counter
    cyc(0, 0, 0, 1, 8'hAA, 0);
    cyc(0, 0, 0, 1, 8'hBB, 0);
    cyc(1, 1, 0, 1, 8'hCC, 0);
    chk("rf_full", {31'd0, in_ready}, 32'd0);
    chk("rf_stall_before", {16'd0, stall}, 32'd5);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("rf_valid", {31'd0, out_valid}, 32'd0);
    chk("rf_data", {24'd0, out_data}, 32'd0);
    chk("rf_ready", {31'd0, in_ready}, 32'd1);
    chk("rf_stall", {16'd0, stall}, 32'd0);

    // Saturation on the 4-bit counter instance
    s_in_valid = 1'b1; s_in_data = 8'h05; s_out_ready = 1'b0;
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("sat_start", {28'd0, s_stall}, 32'd0);
    s_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, 0, 0, 8'h00, 1);
      chk("sat_count", {28'd0, s_stall}, (k > 15) ? 32'd15 : 32'(k));
    end
    chk("sat_data", {24'd0, s_out_data}, 32'h05);

    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
